// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage feeding the control decoder. Owns the PC, reads
// instruction words over an Avalon-style port with waitrequest, latches each
// word into an instruction register and exposes the decoder fields. Taken
// branches/jumps are applied with a one-instruction delay slot. The unit
// stops for good (until reset) once the PC reaches HALT_ADDR.
//
// Ports
//   clk              in   clock, rising edge
//   reset_n          in   synchronous active-low reset
//   mem_address      out  [31:0] byte address of the read (== PC)
//   mem_read         out  read request
//   mem_waitrequest  in   memory stall, request must be held
//   mem_readdata     in   [31:0] instruction word, valid when not stalled
//   advance          in   decoder consumed the current instruction
//   redirect         in   current instruction is a taken branch/jump
//   redirect_target  in   [31:0] branch/jump destination (bits [1:0] dropped)
//   instr            out  [31:0] instruction register
//   opcode           out  [5:0]  instr[31:26]
//   function_code    out  [5:0]  instr[5:0]
//   b_code           out  [4:0]  instr[20:16]
//   pc_out           out  [31:0] address of instr
//   link_addr        out  [31:0] pc_out + 8, wraps at 2^32
//   instr_valid      out  instr holds a fetched, unconsumed instruction
//   active           out  low once halted
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  function_code,
  output logic [4:0]  b_code,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  output logic        instr_valid,
  output logic        active
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    HOLD   = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        mem_read_q, mem_read_d;
  logic        instr_valid_q, instr_valid_d;
  logic        active_q, active_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic [31:0] next_pc_s;

  // Address that follows the current instruction: a latched branch target
  // takes priority once its delay slot is being consumed.
  always_comb begin
    next_pc_s = pc_q + 32'd4;
    if (pending_q) begin
      next_pc_s = pending_target_q;
    end else begin
      next_pc_s = pc_q + 32'd4;
    end
  end

  // Next-state and next-output logic for the fetch controller.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    instr_d          = instr_q;
    mem_read_d       = mem_read_q;
    instr_valid_d    = instr_valid_q;
    active_d         = active_q;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;

    case (state_q)
      FETCH: begin
        active_d = 1'b1;
        // A read only completes while it is actually being requested. The
        // first FETCH cycle after reset has mem_read low and just issues it.
        if (mem_read_q && !mem_waitrequest) begin
          instr_d       = mem_readdata;
          state_d       = HOLD;
          mem_read_d    = 1'b0;
          instr_valid_d = 1'b1;
        end else begin
          mem_read_d    = 1'b1;
          instr_valid_d = 1'b0;
        end
      end

      HOLD: begin
        active_d = 1'b1;
        if (advance) begin
          pc_d          = next_pc_s;
          instr_valid_d = 1'b0;
          // A redirect in the delay slot of an earlier branch is dropped.
          if (pending_q) begin
            pending_d = 1'b0;
          end else if (redirect) begin
            pending_d        = 1'b1;
            pending_target_d = redirect_target & WORD_MASK;
          end else begin
            pending_d = 1'b0;
          end
          if (next_pc_s == HALT_ADDR) begin
            state_d    = HALTED;
            mem_read_d = 1'b0;
            active_d   = 1'b0;
          end else begin
            state_d    = FETCH;
            mem_read_d = 1'b1;
          end
        end else begin
          mem_read_d    = 1'b0;
          instr_valid_d = 1'b1;
        end
      end

      HALTED: begin
        mem_read_d    = 1'b0;
        instr_valid_d = 1'b0;
        active_d      = 1'b0;
      end

      default: begin
        // Unreachable encoding: park quietly until reset.
        state_d       = HALTED;
        mem_read_d    = 1'b0;
        instr_valid_d = 1'b0;
        active_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; a reset
  // during a stalled read drops mem_read on the next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= FETCH;
      pc_q             <= RESET_VECTOR & WORD_MASK;
      instr_q          <= 32'h0000_0000;
      mem_read_q       <= 1'b0;
      instr_valid_q    <= 1'b0;
      active_q         <= 1'b1;
      pending_q        <= 1'b0;
      pending_target_q <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      instr_q          <= instr_d;
      mem_read_q       <= mem_read_d;
      instr_valid_q    <= instr_valid_d;
      active_q         <= active_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
    end
  end

  assign mem_address   = pc_q;
  assign mem_read      = mem_read_q;
  assign instr         = instr_q;
  assign opcode        = instr_q[31:26];
  assign function_code = instr_q[5:0];
  assign b_code        = instr_q[20:16];
  assign pc_out        = pc_q;
  assign link_addr     = pc_q + 32'd8;
  assign instr_valid   = instr_valid_q;
  assign active        = active_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        advance;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  function_code;
  logic [4:0]  b_code;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        instr_valid;
  logic        active;

  int errors = 0;
  int checks = 0;

  // Expected presented instructions: {pc, word}
  logic [63:0] sb_q[$];
  logic        prev_valid = 1'b0;

  instr_fetch dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .advance         (advance),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr           (instr),
    .opcode          (opcode),
    .function_code   (function_code),
    .b_code          (b_code),
    .pc_out          (pc_out),
    .link_addr       (link_addr),
    .instr_valid     (instr_valid),
    .active          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each newly presented instruction is matched against the scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] epc, ew;
    if (reset_n && instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected no instruction", pc_out, instr);
      end else begin
        e   = sb_q.pop_front();
        epc = e[63:32];
        ew  = e[31:0];
        chk("sb_pc_out", pc_out, epc);
        chk("sb_instr", instr, ew);
        chk("sb_opcode", {26'd0, opcode}, {26'd0, ew[31:26]});
        chk("sb_function_code", {26'd0, function_code}, {26'd0, ew[5:0]});
        chk("sb_b_code", {27'd0, b_code}, {27'd0, ew[20:16]});
        chk("sb_link_addr", link_addr, epc + 32'd8);
      end
    end
    prev_valid <= instr_valid;
  end

  // Called at a negedge where the read of addr should already be presented.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int nwait);
    chk("fetch_read", {31'd0, mem_read}, 32'd1);
    chk("fetch_addr", mem_address, addr);
    for (int i = 0; i < nwait; i++) begin
      mem_waitrequest = 1'b1;
      mem_readdata    = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stall_read", {31'd0, mem_read}, 32'd1);
      chk("stall_addr", mem_address, addr);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    mem_waitrequest = 1'b0;
    mem_readdata    = word;
    sb_q.push_back({addr, word});
    @(negedge clk);
    mem_readdata = 32'hDEAD_BEEF;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_read", {31'd0, mem_read}, 32'd0);
  endtask

  // Called at a negedge in HOLD: pulse advance for one cycle.
  task automatic do_advance(input logic redir, input logic [31:0] target);
    advance         = 1'b1;
    redirect        = redir;
    redirect_target = target;
    @(negedge clk);
    advance         = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0000_0000;
    chk("valid_fall", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic check_halted(input logic [31:0] last_word);
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_read", {31'd0, mem_read}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_instr", instr, last_word);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h0000_0000;
    advance         = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0000_0000;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_read", {31'd0, mem_read}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_pc", pc_out, 32'hBFC0_0000);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: first fetch, fields by hand
    do_fetch(32'hBFC0_0000, 32'h3C0A_1234, 0);
    chk("t1_opcode", {26'd0, opcode}, 32'd15);
    chk("t1_func", {26'd0, function_code}, 32'd52);
    chk("t1_bcode", {27'd0, b_code}, 32'd10);
    chk("t1_link", link_addr, 32'hBFC0_0008);
    do_advance(1'b0, 32'h0000_0000);

    // 2: three-cycle stall
    do_fetch(32'hBFC0_0004, 32'h0411_003F, 3);

    // 3: idle in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_read", {31'd0, mem_read}, 32'd0);
      chk("idle_valid", {31'd0, instr_valid}, 32'd1);
      chk("idle_pc", pc_out, 32'hBFC0_0004);
    end

    // 4: branch with delay slot; low target bits dropped; slot redirect ignored
    do_advance(1'b1, 32'hBFC0_0101);
    do_fetch(32'hBFC0_0008, 32'h0085_1020, 0);
    do_advance(1'b1, 32'hBFC0_0200);
    do_fetch(32'hBFC0_0100, 32'h0800_0003, 1);
    do_advance(1'b1, 32'hBFC0_000C);
    do_fetch(32'hBFC0_0104, 32'h8D2A_0004, 0);
    do_advance(1'b0, 32'h0000_0000);
    do_fetch(32'hBFC0_000C, 32'h2442_0001, 0);
    do_advance(1'b0, 32'h0000_0000);

    // 5: redirect to HALT_ADDR halts after the delay slot
    do_fetch(32'hBFC0_0010, 32'h1000_FFFB, 0);
    do_advance(1'b1, 32'h0000_0000);
    do_fetch(32'hBFC0_0014, 32'hAC4B_0008, 2);
    do_advance(1'b0, 32'h0000_0000);
    check_halted(32'hAC4B_0008);
    chk("halt_pc", pc_out, 32'h0000_0000);
    for (int i = 0; i < 10; i++) begin
      advance         = 1'b1;
      mem_waitrequest = i[0];
      @(negedge clk);
      check_halted(32'hAC4B_0008);
    end
    advance         = 1'b0;
    mem_waitrequest = 1'b0;

    // 6: reset during a stalled fetch with a branch pending
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_fetch(32'hBFC0_0000, 32'h3C0A_1234, 0);
    do_advance(1'b1, 32'hBFC0_0300);
    chk("t6_read", {31'd0, mem_read}, 32'd1);
    chk("t6_addr", mem_address, 32'hBFC0_0004);
    mem_waitrequest = 1'b1;
    @(negedge clk);
    chk("t6_stall_read", {31'd0, mem_read}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_abort_read", {31'd0, mem_read}, 32'd0);
    chk("t6_abort_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_abort_instr", instr, 32'h0000_0000);
    reset_n         = 1'b1;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    do_fetch(32'hBFC0_0000, 32'h3C0A_1234, 0);
    do_advance(1'b0, 32'h0000_0000);
    do_fetch(32'hBFC0_0004, 32'h0411_003F, 1);
    do_advance(1'b0, 32'h0000_0000);
    // pending must be gone: sequential address, not BFC00300
    do_fetch(32'hBFC0_0008, 32'h0085_1020, 0);

    // Wrap boundary: FFFFFFFC + 4 = 0 = HALT_ADDR
    do_advance(1'b1, 32'hFFFF_FFFE);
    do_fetch(32'hBFC0_000C, 32'h2442_0001, 0);
    do_advance(1'b0, 32'h0000_0000);
    do_fetch(32'hFFFF_FFFC, 32'h0000_000D, 2);
    chk("wrap_link", link_addr, 32'h0000_0004);
    do_advance(1'b0, 32'h0000_0000);
    check_halted(32'h0000_000D);
    chk("wrap_pc", pc_out, 32'h0000_0000);

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
